aes256_round_seq: RTL and testbench

- Round sequencer for the AES-256 encrypt datapath; drives the load enable and input-select of the 16x8-bit state register.
- Counts the 14 rounds and publishes the current round index to the key schedule.
- Stalls a round when its round key is not ready.
- Holds the finished ciphertext valid until the consumer acknowledges it.

---
 rtl/aes256_round_seq_if.sv | 35 +++
 rtl/aes256_round_seq.sv | 97 +++++++++
 tb/tb_aes256_round_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes256_round_seq_if.sv
// Handshake/control bundle between the AES-256 round sequencer and its datapath/key schedule.
// The abort wire exists only when AES_ROUND_SEQ_ABORT_EN is defined.
interface aes256_round_seq_if;
  logic       start;
  logic       key_ready;
  logic       out_ack;
  logic       busy;
  logic       reg_read;
  logic [1:0] sel_in;
  logic [3:0] round_idx;
  logic       out_valid;
`ifdef AES_ROUND_SEQ_ABORT_EN
  logic       abort;

  modport master (
    output start, key_ready, out_ack, abort,
    input  busy, reg_read, sel_in, round_idx, out_valid
  );

  modport slave (
    input  start, key_ready, out_ack, abort,
    output busy, reg_read, sel_in, round_idx, out_valid
  );
`else
  modport master (
    output start, key_ready, out_ack,
    input  busy, reg_read, sel_in, round_idx, out_valid
  );

  modport slave (
    input  start, key_ready, out_ack,
    output busy, reg_read, sel_in, round_idx, out_valid
  );
`endif
endinterface

// File: rtl/aes256_round_seq.sv
// Round sequencer for the AES-256 encrypt datapath: state-register load/select and round index.
// Optional abort input enabled by defining AES_ROUND_SEQ_ABORT_EN.
module aes256_round_seq #(
  parameter int unsigned NR        = 14,
  parameter int unsigned ROUND_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  aes256_round_seq_if.slave bus
);
  localparam int unsigned   CW     = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(ROUND_LAT - 1);
  localparam logic [3:0]    R_LAST = 4'(NR);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    r, r_nxt;
  logic [CW-1:0] c, c_nxt;
  logic          abort_c;

`ifdef AES_ROUND_SEQ_ABORT_EN
  assign abort_c = bus.abort;
`else
  assign abort_c = 1'b0;
`endif

  // State, round and latency counters
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state <= IDLE;
      r     <= 4'd0;
      c     <= '0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      c     <= c_nxt;
    end
  end

  // Next state and outputs; only reg_read in ROUND looks at an input (key_ready)
  always_comb begin
    state_nxt     = state;
    r_nxt         = r;
    c_nxt         = c;
    bus.busy      = (state != IDLE);
    bus.reg_read  = 1'b0;
    bus.sel_in    = 2'd0;
    bus.round_idx = 4'd0;
    bus.out_valid = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) state_nxt = LOAD;
      end
      LOAD: begin
        bus.reg_read = 1'b1;
        state_nxt    = ROUND;
        r_nxt        = 4'd1;
        c_nxt        = '0;
      end
      ROUND: begin
        bus.round_idx = r;
        bus.sel_in    = (r == R_LAST) ? 2'd2 : 2'd1;
        if (c != C_LAST) begin
          c_nxt = c + CW'(1);
        end else if (bus.key_ready) begin
          bus.reg_read = 1'b1;
          if (r == R_LAST) begin
            state_nxt = DONE;
          end else begin
            r_nxt = r + 4'd1;
            c_nxt = '0;
          end
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.round_idx = R_LAST;
        if (bus.out_ack) begin
          state_nxt = IDLE;
          r_nxt     = 4'd0;
          c_nxt     = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort wins over everything outside IDLE and suppresses the pending load
    if (abort_c && (state != IDLE)) begin
      state_nxt    = IDLE;
      r_nxt        = 4'd0;
      c_nxt        = '0;
      bus.reg_read = 1'b0;
    end
  end
endmodule

// File: tb/tb_aes256_round_seq.sv
// Self-checking bench for aes256_round_seq: per-cycle expected trace queue, directed steps.
// Covers reset, nominal block, key stall, DONE hold, ROUND_LAT=3 and (if built) abort.
module tb_aes256_round_seq;
  localparam int unsigned NR = 14;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  aes256_round_seq_if if0 ();
  aes256_round_seq_if if1 ();

  aes256_round_seq #(.NR(NR), .ROUND_LAT(1)) u0 (.clk(clk), .resetn(resetn), .bus(if0));
  aes256_round_seq #(.NR(NR), .ROUND_LAT(3)) u1 (.clk(clk), .resetn(resetn), .bus(if1));

  typedef struct packed {
    logic       busy;
    logic       rr;
    logic [1:0] sel;
    logic [3:0] idx;
    logic       ov;
    logic       chk_sel;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   dut_sel  = 0;
  int   kr_lo    = -1;
  int   kr_hi    = -2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t obs();
    exp_t o;
    if (dut_sel == 0) begin
      o.busy = if0.busy; o.rr = if0.reg_read; o.sel = if0.sel_in;
      o.idx  = if0.round_idx; o.ov = if0.out_valid;
    end else begin
      o.busy = if1.busy; o.rr = if1.reg_read; o.sel = if1.sel_in;
      o.idx  = if1.round_idx; o.ov = if1.out_valid;
    end
    o.chk_sel = 1'b1;
    return o;
  endfunction

  // Expected per-cycle trace from LOAD up to the first DONE cycle
  function automatic void push_block(input int lat, input int stall_round, input int stall_len);
    int   n;
    exp_t e;
    e = '{busy: 1'b1, rr: 1'b1, sel: 2'd0, idx: 4'd0, ov: 1'b0, chk_sel: 1'b1};
    q.push_back(e);
    for (int k = 1; k <= int'(NR); k++) begin
      n = lat + ((k == stall_round) ? stall_len : 0);
      for (int j = 0; j < n; j++) begin
        e = '{busy: 1'b1, rr: (j == n - 1), sel: (k == int'(NR)) ? 2'd2 : 2'd1,
              idx: 4'(k), ov: 1'b0, chk_sel: 1'b1};
        q.push_back(e);
      end
    end
    e = '{busy: 1'b1, rr: 1'b0, sel: 2'd0, idx: 4'(NR), ov: 1'b1, chk_sel: 1'b0};
    q.push_back(e);
  endfunction

  task automatic tick();
    exp_t e;
    exp_t o;
    @(posedge clk);
    #1;
    cyc++;
    if0.key_ready = !(cyc >= kr_lo && cyc <= kr_hi);
    if1.key_ready = if0.key_ready;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      o = obs();
      if (!e.chk_sel) o.sel = e.sel;
      o.chk_sel = e.chk_sel;
      check("trace", 32'(o), 32'(e));
    end
  endtask

  task automatic set_start(input logic v);
    if (dut_sel == 0) if0.start = v; else if1.start = v;
  endtask

  task automatic launch(input int lat, input int stall_round, input int stall_len);
    set_start(1'b1);
    push_block(lat, stall_round, stall_len);
    tick();
    set_start(1'b0);
  endtask

  task automatic drain();
    while (q.size() > 0) tick();
  endtask

  task automatic ack_block();
    exp_t o;
    if0.out_ack = 1'b1;
    if1.out_ack = 1'b1;
    tick();
    if0.out_ack = 1'b0;
    if1.out_ack = 1'b0;
    o = obs();
    check("ack_idle", 32'({o.busy, o.ov, o.rr}), 32'(0));
  endtask

  task automatic wait_round(input logic [3:0] target, input string tag);
    int n;
    exp_t o;
    n = 0;
    o = obs();
    while (o.idx != target && n < 60) begin
      tick();
      o = obs();
      n++;
    end
    check(tag, 32'(o.idx), 32'(target));
  endtask

  initial begin
    exp_t o;
    resetn        = 1'b0;
    if0.start     = 1'b0; if0.key_ready = 1'b1; if0.out_ack = 1'b0;
    if1.start     = 1'b0; if1.key_ready = 1'b1; if1.out_ack = 1'b0;
`ifdef AES_ROUND_SEQ_ABORT_EN
    if0.abort     = 1'b0;
    if1.abort     = 1'b0;
`endif
    #2 resetn = 1'b1;
    #1;
    check("rst_u0", 32'({if0.busy, if0.reg_read, if0.sel_in, if0.round_idx, if0.out_valid}), 32'(0));
    check("rst_u1", 32'({if1.busy, if1.reg_read, if1.sel_in, if1.round_idx, if1.out_valid}), 32'(0));
    #14 resetn = 1'b0;
    tick();
    tick();
    check("idle_after_rst", 32'({if0.busy, if0.reg_read}), 32'(0));

    // Nominal block on LAT=1
    dut_sel = 0;
    launch(1, 0, 0);
    drain();
    ack_block();

    // Key stall of three cycles at round 5's load cycle
    kr_lo = cyc + 1 + 5;
    kr_hi = kr_lo + 2;
    launch(1, 5, 3);
    drain();
    kr_lo = -1; kr_hi = -2;
    ack_block();

    // DONE held without ack; starts during DONE must not relaunch
    launch(1, 0, 0);
    drain();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) set_start(1'b1);
      tick();
      set_start(1'b0);
      o = obs();
      check("done_hold", 32'({o.busy, o.rr, o.idx, o.ov}), 32'({1'b1, 1'b0, 4'(NR), 1'b1}));
    end
    set_start(1'b1);
    ack_block();
    set_start(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      o = obs();
      check("no_relaunch", 32'({o.busy, o.rr}), 32'(0));
    end

    // Asynchronous reset in the middle of round 7
    launch(1, 0, 0);
    wait_round(4'd7, "reach_r7");
    q.delete();
    #2 resetn = 1'b1;
    #1;
    check("rst_mid", 32'({if0.busy, if0.reg_read, if0.sel_in, if0.round_idx, if0.out_valid}), 32'(0));
    #2 resetn = 1'b0;
    tick();
    tick();
    check("idle_post_rst", 32'({if0.busy, if0.reg_read, if0.out_valid}), 32'(0));

    // ROUND_LAT = 3 instance
    dut_sel = 1;
    launch(3, 0, 0);
    drain();
    ack_block();

`ifdef AES_ROUND_SEQ_ABORT_EN
    // Abort at round 9 load cycle, then a clean block
    dut_sel = 0;
    launch(1, 0, 0);
    wait_round(4'd9, "reach_r9");
    q.delete();
    if0.abort = 1'b1;
    #1;
    check("abort_rr", 32'(if0.reg_read), 32'(0));
    tick();
    if0.abort = 1'b0;
    check("abort_idle", 32'({if0.busy, if0.out_valid, if0.round_idx}), 32'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_quiet", 32'({if0.busy, if0.reg_read}), 32'(0));
    end
    launch(1, 0, 0);
    drain();
    ack_block();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
